// File: rtl/video_field_sink_if.sv
// Avalon-ST video stream bundle between an upstream video source and the field sink.
interface video_field_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/video_field_sink.sv
// Deinterlacer input: parses control/video packets and fills ping-pong line buffers,
// notifying the line-doubling source of each completed line.
//
// state   | meaning
// IDLE    | waiting for SOP, decode packet type
// CTRL    | collecting width/height nibbles of a control packet
// VWAIT   | stalled until the target line buffer is empty
// VLINE   | writing pixels of the current line into the target buffer
// VDRAIN  | field complete, dropping surplus beats until EOP
// DISCARD | unknown packet type, dropping beats until EOP
module video_field_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int DEF_WIDTH  = 720,
  parameter int DEF_HEIGHT = 288,
  parameter int MAX_WIDTH  = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  video_field_sink_if.slave     din,
  output logic                  wr_req0,
  output logic [DATA_WIDTH-1:0] wr_data0,
  input  logic                  full0,
  output logic                  wr_req1,
  output logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  full1,
  output logic                  ready_to_continue,
  input  logic                  aver_sent,
  output logic [15:0]           frame_width,
  output logic [15:0]           frame_height,
  output logic                  field_done,
  output logic                  proto_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CTRL    = 3'd1;
  localparam logic [2:0] VWAIT   = 3'd2;
  localparam logic [2:0] VLINE   = 3'd3;
  localparam logic [2:0] VDRAIN  = 3'd4;
  localparam logic [2:0] DISCARD = 3'd5;

  logic [2:0]  state;
  logic        alive;
  logic        target;
  logic [9:0]  px;
  logic [15:0] line;
  logic [3:0]  nib_cnt;
  logic [15:0] sh_width;
  logic [15:0] sh_height;

  logic       xfer;
  logic       sop;
  logic       eop;
  logic [3:0] nib;
  logic       last_px;
  logic       last_line;
  logic       dims_ok;
  logic       target_full;

  // alive keeps din_ready low while reset is held, even though IDLE is otherwise ready
  assign din.ready   = alive && (state != VWAIT);
  assign xfer        = din.valid && din.ready;
  assign sop         = din.startofpacket;
  assign eop         = din.endofpacket;
  assign nib         = din.data[3:0];
  assign last_px     = (px == (frame_width[9:0] - 10'd1));
  assign last_line   = (line == (frame_height - 16'd1));
  assign target_full = target ? full1 : full0;
  assign dims_ok     = (nib_cnt == 4'd8) && (sh_width != 16'd0) &&
                       (sh_width <= 16'(MAX_WIDTH)) && (sh_height != 16'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      alive             <= 1'b0;
      target            <= 1'b0;
      px                <= '0;
      line              <= '0;
      nib_cnt           <= '0;
      sh_width          <= '0;
      sh_height         <= '0;
      wr_req0           <= 1'b0;
      wr_req1           <= 1'b0;
      wr_data0          <= '0;
      wr_data1          <= '0;
      ready_to_continue <= 1'b0;
      frame_width       <= 16'(DEF_WIDTH);
      frame_height      <= 16'(DEF_HEIGHT);
      field_done        <= 1'b0;
      proto_err         <= 1'b0;
    end else begin
      alive      <= 1'b1;
      wr_req0    <= 1'b0;
      wr_req1    <= 1'b0;
      field_done <= 1'b0;
      proto_err  <= 1'b0;
      if (aver_sent) ready_to_continue <= 1'b0;

      case (state)
        IDLE: begin
          if (xfer && sop && !eop) begin
            if (nib == 4'hF) begin
              state   <= CTRL;
              nib_cnt <= '0;
            end else if (nib == 4'h0) begin
              state <= VWAIT;
              px    <= '0;
              line  <= '0;
            end else begin
              state <= DISCARD;
            end
          end
        end
        CTRL: begin
          if (xfer) begin
            if (nib_cnt < 4'd4)      sh_width  <= {sh_width[11:0], nib};
            else if (nib_cnt < 4'd8) sh_height <= {sh_height[11:0], nib};
            if (nib_cnt != 4'hF) nib_cnt <= nib_cnt + 4'd1;
            if (eop) begin
              state <= IDLE;
              if (dims_ok) begin
                frame_width  <= sh_width;
                frame_height <= sh_height;
              end else begin
                proto_err <= 1'b1;
              end
            end
          end
        end
        VWAIT: begin
          if (!target_full) state <= VLINE;
        end
        VLINE: begin
          if (xfer) begin
            if (target) begin
              wr_req1  <= 1'b1;
              wr_data1 <= din.data;
            end else begin
              wr_req0  <= 1'b1;
              wr_data0 <= din.data;
            end
            if (eop && !(last_px && last_line)) begin
              proto_err <= 1'b1;
              state     <= IDLE;
            end else if (last_px) begin
              px                <= '0;
              line              <= line + 16'd1;
              target            <= ~target;
              ready_to_continue <= 1'b1;
              if (last_line) begin
                field_done <= 1'b1;
                state      <= eop ? IDLE : VDRAIN;
              end else begin
                state <= VWAIT;
              end
            end else begin
              px <= px + 10'd1;
            end
          end
        end
        VDRAIN: begin
          // any beat reaching here is surplus to the field
          if (xfer && eop) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DISCARD: begin
          if (xfer && eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_field_sink.sv
// Directed bench for video_field_sink: control-packet vector table plus video sequences.
module tb_video_field_sink;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  video_field_sink_if #(.DATA_WIDTH(8)) din_if ();

  logic        wr_req0, wr_req1, ready_to_continue, field_done, proto_err;
  logic [7:0]  wr_data0, wr_data1;
  logic [15:0] frame_width, frame_height;
  logic        full0 = 1'b0;
  logic        full1 = 1'b0;
  logic        aver_sent = 1'b0;

  video_field_sink #(.DATA_WIDTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .din               (din_if.slave),
    .wr_req0           (wr_req0),
    .wr_data0          (wr_data0),
    .full0             (full0),
    .wr_req1           (wr_req1),
    .wr_data1          (wr_data1),
    .full1             (full1),
    .ready_to_continue (ready_to_continue),
    .aver_sent         (aver_sent),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .field_done        (field_done),
    .proto_err         (proto_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // write log {buffer, data}, event counters, auto-acknowledge of ready_to_continue
  logic [8:0] wq[$];
  int   pe_cnt = 0, fd_cnt = 0, rtc_cnt = 0;
  logic rtc_q = 1'b0;
  logic prev_x = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_x    = 1'b0;
      rtc_q     = 1'b0;
      aver_sent = 1'b0;
    end else begin
      if (wr_req0 || wr_req1) begin
        tests++;
        if (!prev_x || (wr_req0 && wr_req1) || ((wr_req0 ? wr_data0 : wr_data1) !== prev_d)) begin
          fails++;
          $display("FAIL write_latency: req0=%b req1=%b data=%0h, expected one write of %0h after a transfer",
                   wr_req0, wr_req1, wr_req0 ? wr_data0 : wr_data1, prev_d);
        end
        wq.push_back({wr_req1, wr_req0 ? wr_data0 : wr_data1});
      end
      if (proto_err) pe_cnt++;
      if (field_done) fd_cnt++;
      if (ready_to_continue && !rtc_q) rtc_cnt++;
      rtc_q     = ready_to_continue;
      aver_sent = ready_to_continue;
      prev_x    = din_if.valid && din_if.ready;
      prev_d    = din_if.data;
    end
  end

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    @(posedge clock); #1;
    din_if.data = d; din_if.valid = 1'b1;
    din_if.startofpacket = s; din_if.endofpacket = e;
    @(negedge clock);
    while (!din_if.ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      fails++;
      $display("FAIL ready_timeout: din_ready low for %0d cycles, required high", n);
    end
    @(posedge clock); #1;
    din_if.valid = 1'b0; din_if.startofpacket = 1'b0; din_if.endofpacket = 1'b0;
  endtask

  task automatic ctrl_pkt(input logic [15:0] w, input logic [15:0] h);
    beat(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat({4'h0, w[15-4*i -: 4]}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat({4'h0, h[15-4*i -: 4]}, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b1);
  endtask

  task automatic video(input logic [7:0] hdr, input int n, input logic [7:0] start);
    beat(hdr, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) beat(start + 8'(i * 17), 1'b0, i == n - 1);
  endtask

  task automatic check_writes(input string name, input int n, input logic [7:0] start,
                              input int w, input logic first_buf);
    logic b;
    repeat (3) @(negedge clock);
    check({name, "_count"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      b = first_buf ^ logic'((i / w) % 2);
      check({name, "_write"}, wq[i], {b, start + 8'(i * 17)});
    end
    wq.delete();
  endtask

  typedef struct {
    int          n;
    logic [43:0] nibs;
    logic [15:0] exp_w;
    logic [15:0] exp_h;
    int          exp_err;
  } ctrl_vec_t;

  ctrl_vec_t cv[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe0, fd0, rtc0, stall_bad;
    din_if.data = 8'h00; din_if.valid = 1'b0;
    din_if.startofpacket = 1'b0; din_if.endofpacket = 1'b0;

    cv[0] = '{9,  44'h00080010200, 16'd8,    16'd16, 0};
    cv[1] = '{8,  44'h00040002000, 16'd8,    16'd16, 1};
    cv[2] = '{4,  44'h00040000000, 16'd8,    16'd16, 1};
    cv[3] = '{9,  44'h00000005100, 16'd8,    16'd16, 1};
    cv[4] = '{9,  44'h04000001000, 16'd8,    16'd16, 1};
    cv[5] = '{9,  44'h03FF0001300, 16'd1023, 16'd1,  0};
    cv[6] = '{9,  44'h00050000000, 16'd1023, 16'd1,  1};
    cv[7] = '{11, 44'h00060006000, 16'd1023, 16'd1,  1};
    cv[8] = '{9,  44'h00040002F00, 16'd4,    16'd2,  0};
    cv[9] = '{1,  44'h00000000000, 16'd4,    16'd2,  1};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_din_ready", din_if.ready, 0);
    check("rst_wr_req0", wr_req0, 0);
    check("rst_wr_req1", wr_req1, 0);
    check("rst_wr_data0", wr_data0, 0);
    check("rst_wr_data1", wr_data1, 0);
    check("rst_rtc", ready_to_continue, 0);
    check("rst_field_done", field_done, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_width", frame_width, 720);
    check("rst_height", frame_height, 288);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_din_ready", din_if.ready, 1);

    // control packet table
    for (int v = 0; v < 10; v++) begin
      pe0 = pe_cnt;
      beat(8'hAF, 1'b1, 1'b0);
      for (int i = 0; i < cv[v].n; i++)
        beat({4'h5, cv[v].nibs[43-4*i -: 4]}, 1'b0, i == cv[v].n - 1);
      repeat (2) @(negedge clock);
      check($sformatf("ctrl%0d_width", v), frame_width, cv[v].exp_w);
      check($sformatf("ctrl%0d_height", v), frame_height, cv[v].exp_h);
      check($sformatf("ctrl%0d_err", v), pe_cnt - pe0, cv[v].exp_err);
    end
    wq.delete();

    // normal 4x2 field, final pixel carries EOP
    pe0 = pe_cnt; fd0 = fd_cnt; rtc0 = rtc_cnt;
    video(8'h00, 8, 8'h11);
    check_writes("field", 8, 8'h11, 4, 1'b0);
    check("field_rtc", rtc_cnt - rtc0, 2);
    check("field_done", fd_cnt - fd0, 1);
    check("field_err", pe_cnt - pe0, 0);
    ctrl_pkt(16'd2, 16'd2);
    repeat (2) @(negedge clock);
    check("after_field_idle", frame_width, 2);
    ctrl_pkt(16'd4, 16'd2);

    // buffer 1 full at line start stalls the stream
    full1 = 1'b1;
    fd0 = fd_cnt; stall_bad = 0;
    beat(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'h11 + 8'(i * 17), 1'b0, 1'b0);
    fork
      beat(8'h55, 1'b0, 1'b0);
      begin
        repeat (10) begin
          @(negedge clock);
          if (din_if.ready) stall_bad++;
        end
        full1 = 1'b0;
      end
    join
    check("stall_ready_low", stall_bad, 0);
    for (int i = 5; i < 8; i++) beat(8'h11 + 8'(i * 17), 1'b0, i == 7);
    check_writes("stall", 8, 8'h11, 4, 1'b0);
    check("stall_field_done", fd_cnt - fd0, 1);

    // early EOP after 6 of 8 pixels
    pe0 = pe_cnt; fd0 = fd_cnt; rtc0 = rtc_cnt;
    video(8'h00, 6, 8'h11);
    check_writes("early", 6, 8'h11, 4, 1'b0);
    check("early_err", pe_cnt - pe0, 1);
    check("early_field_done", fd_cnt - fd0, 0);
    check("early_rtc", rtc_cnt - rtc0, 1);
    // next field starts in buffer 1 since the partial line did not toggle
    pe0 = pe_cnt; fd0 = fd_cnt;
    video(8'h50, 8, 8'hA0);
    check_writes("next", 8, 8'hA0, 4, 1'b1);
    check("next_err", pe_cnt - pe0, 0);
    check("next_field_done", fd_cnt - fd0, 1);

    // reset in the middle of a video line
    beat(8'h00, 1'b1, 1'b0);
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_din_ready", din_if.ready, 0);
    check("midrst_wr_req0", wr_req0, 0);
    check("midrst_wr_req1", wr_req1, 0);
    check("midrst_width", frame_width, 720);
    check("midrst_height", frame_height, 288);
    repeat (2) @(negedge clock);
    wq.delete();
    @(posedge clock); #1 reset = 1'b0;

    // unknown packet type is dropped silently
    pe0 = pe_cnt;
    beat(8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'hC0 + 8'(i), 1'b0, i == 3);
    check_writes("discard", 0, 8'h00, 4, 1'b0);
    check("discard_err", pe_cnt - pe0, 0);

    // one-line field after reset lands in buffer 0
    ctrl_pkt(16'd4, 16'd1);
    pe0 = pe_cnt; fd0 = fd_cnt;
    video(8'h00, 4, 8'h30);
    check_writes("postrst", 4, 8'h30, 4, 1'b0);
    check("postrst_field_done", fd_cnt - fd0, 1);
    check("postrst_err", pe_cnt - pe0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
